// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths and fetch constants
package cpu_pkg;
    localparam int PC_W = 16;
    localparam int INSTR_W = 17;
    localparam int FQ_DEPTH = 2;
    localparam logic [PC_W-1:0] RESET_PC = 16'h0000;
    // LLB R0,#0 doubles as the bubble when no instruction is ready
    localparam logic [INSTR_W-1:0] NOP_INSTR = 17'h0B000;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with push/pop/clear and occupancy count
module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // DEPTH is a power of two, so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - instruction fetch stage: PC, IM requests, in-order fetch queue
module pc_fetch #(
    parameter int                  PC_W      = cpu_pkg::PC_W,
    parameter int                  INSTR_W   = cpu_pkg::INSTR_W,
    parameter logic [PC_W-1:0]     RESET_PC  = cpu_pkg::RESET_PC,
    parameter int                  FQ_DEPTH  = cpu_pkg::FQ_DEPTH,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_IM_ID,
    input  logic               flow_change_ID_EX,
    input  logic [PC_W-1:0]    dst_ID_EX,
    output logic               im_req,
    output logic [PC_W-1:0]    im_addr,
    input  logic               im_rdy,
    input  logic               im_rvalid,
    input  logic [INSTR_W-1:0] im_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_vld,
    output logic [PC_W-1:0]    nxt_pc
);
    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam int QW = INSTR_W + PC_W;
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(FQ_DEPTH);

    logic [PC_W-1:0] pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   q_count;
    logic [CW-1:0]   t_count;
    logic [QW-1:0]   q_head;
    logic [PC_W-1:0] tag_head;
    logic            accept;
    logic            resp;
    logic            resp_keep;
    logic            pop;

    // Dropped requests stay in outstanding, so the issue limit also bounds drop_cnt
    assign im_req    = !rst && !flow_change_ID_EX
                       && (({1'b0, q_count} + {1'b0, outstanding}) < DEPTH_L);
    assign im_addr   = pc;
    assign accept    = im_req && im_rdy;
    assign resp      = im_rvalid && (outstanding != '0);
    assign resp_keep = resp && (drop_cnt == '0) && (t_count != '0);
    assign instr_vld = (q_count != '0);
    assign pop       = instr_vld && !stall_IM_ID && !flow_change_ID_EX;

    fetch_fifo #(.WIDTH(PC_W), .DEPTH(FQ_DEPTH)) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (flow_change_ID_EX),
        .push      (accept),
        .push_data (pc),
        .pop       (resp_keep),
        .head      (tag_head),
        .count     (t_count)
    );

    fetch_fifo #(.WIDTH(QW), .DEPTH(FQ_DEPTH)) u_instr_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (flow_change_ID_EX),
        .push      (resp_keep && !flow_change_ID_EX),
        .push_data ({im_rdata, tag_head + PC_W'(1)}),
        .pop       (pop),
        .head      (q_head),
        .count     (q_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(accept) - CW'(resp);
            if (flow_change_ID_EX) begin
                pc       <= dst_ID_EX;
                // everything still in flight after this cycle belongs to the old path
                drop_cnt <= outstanding - CW'(resp);
            end else begin
                if (accept)
                    pc <= pc + PC_W'(1);
                if (resp && (drop_cnt != '0))
                    drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    assign instr  = instr_vld ? q_head[QW-1:PC_W] : NOP_INSTR;
    assign nxt_pc = instr_vld ? q_head[PC_W-1:0] : '0;
endmodule
